// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-master memory port arbiter.
// Imported by the picker and the top level.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_rr_pick2.sv
// Combinational 2-way picker. The round-robin history bit lives in the parent;
// this block only chooses among the currently valid requests.
module arb_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       mode_i,
  output logic [1:0] grant_o,
  output logic       idx_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    idx_o   = MST_IFU;
    grant_o = 2'b00;
    case (req_i)
      2'b01:   idx_o = MST_IFU;
      2'b10:   idx_o = MST_LSU;
      2'b11:   idx_o = mode_i ? MST_LSU : ~last_i;
      default: idx_o = MST_IFU;
    endcase
    if (req_i != 2'b00) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences IFU (master 0) and LSU (master 1) onto one memory port with a
// single outstanding transaction. Only m_req_valid_i -> m_req_ready_o is combinational.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            m_req_valid_i,
  output logic [1:0]            m_req_ready_o,
  input  logic [2*ADDR_W-1:0]   m_addr_i,
  input  logic [1:0]            m_wen_i,
  input  logic [2*DATA_W-1:0]   m_wdata_i,
  input  logic [2*DATA_W/8-1:0] m_wmask_i,
  output logic [1:0]            m_resp_valid_o,
  output logic [DATA_W-1:0]     m_rdata_o,
  output logic                  s_req_valid_o,
  input  logic                  s_req_ready_i,
  output logic [ADDR_W-1:0]     s_addr_o,
  output logic                  s_wen_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  output logic [DATA_W/8-1:0]   s_wmask_o,
  input  logic                  s_resp_valid_i,
  input  logic [DATA_W-1:0]     s_rdata_i,
  output logic                  owner_o
);

  localparam int   STRB_W    = DATA_W / 8;
  localparam logic MODE_FIXD = (PRIO_MODE == PRIO_FIXED);

  state_e              state_q;
  logic                rr_last_q;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wmask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_valid_q;

  logic [1:0]          pick_grant;
  logic                pick_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_wen;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wmask;
  logic                resp_done;

  arb_rr_pick2 u_pick (
    .req_i   (m_req_valid_i),
    .last_i  (rr_last_q),
    .mode_i  (MODE_FIXD),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_addr  = pick_idx ? m_addr_i[ADDR_W +: ADDR_W]  : m_addr_i[0 +: ADDR_W];
    sel_wen   = pick_idx ? m_wen_i[1]                  : m_wen_i[0];
    sel_wdata = pick_idx ? m_wdata_i[DATA_W +: DATA_W] : m_wdata_i[0 +: DATA_W];
    sel_wmask = pick_idx ? m_wmask_i[STRB_W +: STRB_W] : m_wmask_i[0 +: STRB_W];
  end

  // A response only counts once the slave has taken the request.
  assign resp_done = (state_q == ST_RESP && s_resp_valid_i) ||
                     (state_q == ST_REQ && s_req_ready_i && s_resp_valid_i);

  assign m_req_ready_o  = (state_q == ST_IDLE && !rst_i) ? pick_grant : 2'b00;
  assign m_resp_valid_o = resp_valid_q;
  assign m_rdata_o      = rdata_q;
  assign s_req_valid_o  = (state_q == ST_REQ);
  assign s_addr_o       = addr_q;
  assign s_wen_o        = wen_q;
  assign s_wdata_o      = wdata_q;
  assign s_wmask_o      = wmask_q;
  assign owner_o        = owner_q;

  // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= MST_LSU;
      owner_q      <= MST_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 2'b00;
    end else begin
      resp_valid_q <= 2'b00;
      if (resp_done) begin
        rdata_q               <= s_rdata_i;
        resp_valid_q[owner_q] <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (m_req_valid_i != 2'b00) begin
            owner_q   <= pick_idx;
            rr_last_q <= pick_idx;
            addr_q    <= sel_addr;
            wen_q     <= sel_wen;
            wdata_q   <= sel_wdata;
            wmask_q   <= sel_wmask;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (s_req_ready_i) state_q <= s_resp_valid_i ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          if (s_resp_valid_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one round-robin and one fixed-priority
// instance share all inputs; each scenario task checks the relevant instance.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [1:0]   m_req_valid_i;
  logic [63:0]  m_addr_i;
  logic [1:0]   m_wen_i;
  logic [127:0] m_wdata_i;
  logic [15:0]  m_wmask_i;
  logic         s_req_ready_i;
  logic         s_resp_valid_i;
  logic [63:0]  s_rdata_i;

  logic [1:0]  m_req_ready_o, m_resp_valid_o;
  logic [63:0] m_rdata_o, s_wdata_o;
  logic        s_req_valid_o, s_wen_o, owner_o;
  logic [31:0] s_addr_o;
  logic [7:0]  s_wmask_o;

  logic [1:0]  fx_m_req_ready_o, fx_m_resp_valid_o;
  logic [63:0] fx_m_rdata_o, fx_s_wdata_o;
  logic        fx_s_req_valid_o, fx_s_wen_o, fx_owner_o;
  logic [31:0] fx_s_addr_o;
  logic [7:0]  fx_s_wmask_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .PRIO_MODE(PRIO_RR)) dut_rr (
    .clk_i(clk_i), .rst_i(rst_i), .m_req_valid_i(m_req_valid_i), .m_req_ready_o(m_req_ready_o),
    .m_addr_i(m_addr_i), .m_wen_i(m_wen_i), .m_wdata_i(m_wdata_i), .m_wmask_i(m_wmask_i),
    .m_resp_valid_o(m_resp_valid_o), .m_rdata_o(m_rdata_o), .s_req_valid_o(s_req_valid_o),
    .s_req_ready_i(s_req_ready_i), .s_addr_o(s_addr_o), .s_wen_o(s_wen_o), .s_wdata_o(s_wdata_o),
    .s_wmask_o(s_wmask_o), .s_resp_valid_i(s_resp_valid_i), .s_rdata_i(s_rdata_i), .owner_o(owner_o)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .PRIO_MODE(PRIO_FIXED)) dut_fx (
    .clk_i(clk_i), .rst_i(rst_i), .m_req_valid_i(m_req_valid_i), .m_req_ready_o(fx_m_req_ready_o),
    .m_addr_i(m_addr_i), .m_wen_i(m_wen_i), .m_wdata_i(m_wdata_i), .m_wmask_i(m_wmask_i),
    .m_resp_valid_o(fx_m_resp_valid_o), .m_rdata_o(fx_m_rdata_o), .s_req_valid_o(fx_s_req_valid_o),
    .s_req_ready_i(s_req_ready_i), .s_addr_o(fx_s_addr_o), .s_wen_o(fx_s_wen_o), .s_wdata_o(fx_s_wdata_o),
    .s_wmask_o(fx_s_wmask_o), .s_resp_valid_i(s_resp_valid_i), .s_rdata_i(s_rdata_i), .owner_o(fx_owner_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle; registered outputs are settled on return.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    m_req_valid_i = 2'b00; m_addr_i = '0; m_wen_i = 2'b00; m_wdata_i = '0; m_wmask_i = '0;
    s_req_ready_i = 1'b0; s_resp_valid_i = 1'b0; s_rdata_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (m_req_ready_o !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", m_req_ready_o); end
    checks++; if (m_resp_valid_o !== 2'b00) begin errors++; $display("FAIL rst_resp got %b exp 00", m_resp_valid_o); end
    checks++; if (s_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_s_valid got %b exp 0", s_req_valid_o); end
    checks++; if (m_rdata_o !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", m_rdata_o); end
    checks++; if (owner_o !== 1'b0) begin errors++; $display("FAIL rst_owner got %b exp 0", owner_o); end
    checks++; if (dut_rr.state_q !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp 0", dut_rr.state_q); end
    checks++; if (dut_rr.rr_last_q !== 1'b1) begin errors++; $display("FAIL rst_rr_last got %b exp 1", dut_rr.rr_last_q); end
  endtask

  task automatic test_single_read();
    do_reset();
    m_addr_i = {32'h0, 32'h8000_0000}; m_req_valid_i = 2'b01; s_req_ready_i = 1'b1;
    #1;
    checks++; if (m_req_ready_o !== 2'b01) begin errors++; $display("FAIL rd_ready got %b exp 01", m_req_ready_o); end
    tick();
    m_req_valid_i = 2'b00;
    #1;
    checks++; if (s_req_valid_o !== 1'b1) begin errors++; $display("FAIL rd_s_valid got %b exp 1", s_req_valid_o); end
    checks++; if (s_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL rd_s_addr got %h exp 80000000", s_addr_o); end
    checks++; if (s_wen_o !== 1'b0) begin errors++; $display("FAIL rd_s_wen got %b exp 0", s_wen_o); end
    tick();
    s_req_ready_i = 1'b0; s_resp_valid_i = 1'b1; s_rdata_i = 64'h1122_3344_5566_7788;
    #1;
    checks++; if (m_resp_valid_o !== 2'b00) begin errors++; $display("FAIL rd_early_resp got %b exp 00", m_resp_valid_o); end
    tick();
    s_resp_valid_i = 1'b0; s_rdata_i = 64'h0;
    #1;
    checks++; if (m_resp_valid_o !== 2'b01) begin errors++; $display("FAIL rd_resp got %b exp 01", m_resp_valid_o); end
    checks++; if (m_rdata_o !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL rd_rdata got %h exp 1122334455667788", m_rdata_o); end
    checks++; if (s_req_valid_o !== 1'b0) begin errors++; $display("FAIL rd_s_valid_end got %b exp 0", s_req_valid_o); end
    tick();
    checks++; if (m_resp_valid_o !== 2'b00) begin errors++; $display("FAIL rd_resp_pulse got %b exp 00", m_resp_valid_o); end
    checks++; if (m_rdata_o !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL rd_rdata_hold got %h exp 1122334455667788", m_rdata_o); end
  endtask

  task automatic test_rr_contention();
    logic       exp_idx;
    logic [1:0] exp_ready;
    logic [1:0] exp_resp;
    logic [31:0] exp_addr;
    do_reset();
    m_addr_i = {32'h0000_2000, 32'h0000_1000}; m_req_valid_i = 2'b11;
    s_req_ready_i = 1'b1; s_resp_valid_i = 1'b1; s_rdata_i = 64'hA5;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_idx   = (g % 2 == 1);
      exp_ready = exp_idx ? 2'b10 : 2'b01;
      exp_resp  = exp_idx ? 2'b01 : 2'b10;
      exp_addr  = exp_idx ? 32'h0000_2000 : 32'h0000_1000;
      checks++; if (m_req_ready_o !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", g, m_req_ready_o, exp_ready); end
      if (g > 0) begin
        checks++; if (m_resp_valid_o !== exp_resp) begin errors++; $display("FAIL rr_resp[%0d] got %b exp %b", g, m_resp_valid_o, exp_resp); end
      end
      tick();
      checks++; if (owner_o !== exp_idx) begin errors++; $display("FAIL rr_owner[%0d] got %b exp %b", g, owner_o, exp_idx); end
      checks++; if (s_addr_o !== exp_addr) begin errors++; $display("FAIL rr_addr[%0d] got %h exp %h", g, s_addr_o, exp_addr); end
      checks++; if (m_req_ready_o !== 2'b00) begin errors++; $display("FAIL rr_busy_ready[%0d] got %b exp 00", g, m_req_ready_o); end
      tick();
    end
    m_req_valid_i = 2'b00; s_resp_valid_i = 1'b0;
  endtask

  task automatic test_fixed_prio();
    do_reset();
    m_addr_i = {32'h0000_2000, 32'h0000_1000}; m_req_valid_i = 2'b11;
    s_req_ready_i = 1'b1; s_resp_valid_i = 1'b1; s_rdata_i = 64'h5A;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++; if (fx_m_req_ready_o !== 2'b10) begin errors++; $display("FAIL fx_ready[%0d] got %b exp 10", g, fx_m_req_ready_o); end
      tick();
      if (g == 2) m_req_valid_i = 2'b01;
      #1;
      checks++; if (fx_owner_o !== 1'b1) begin errors++; $display("FAIL fx_owner[%0d] got %b exp 1", g, fx_owner_o); end
      tick();
    end
    #1;
    checks++; if (fx_m_req_ready_o !== 2'b01) begin errors++; $display("FAIL fx_ifu_ready got %b exp 01", fx_m_req_ready_o); end
    checks++; if (fx_m_resp_valid_o !== 2'b10) begin errors++; $display("FAIL fx_last_resp got %b exp 10", fx_m_resp_valid_o); end
    m_req_valid_i = 2'b00; s_resp_valid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    m_addr_i = {32'h0, 32'h0000_3000}; m_wen_i = 2'b01;
    m_wdata_i = {64'h0, 64'hCAFE_F00D_1234_5678}; m_wmask_i = {8'h00, 8'hAA};
    m_req_valid_i = 2'b01;
    #1;
    checks++; if (m_req_ready_o !== 2'b01) begin errors++; $display("FAIL bp_grant got %b exp 01", m_req_ready_o); end
    tick();
    m_req_valid_i = 2'b10; m_addr_i[63:32] = 32'h0000_4000;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (s_req_valid_o !== 1'b1) begin errors++; $display("FAIL bp_s_valid[%0d] got %b exp 1", i, s_req_valid_o); end
      checks++; if (s_addr_o !== 32'h0000_3000) begin errors++; $display("FAIL bp_addr[%0d] got %h exp 3000", i, s_addr_o); end
      checks++; if (s_wdata_o !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("FAIL bp_wdata[%0d] got %h exp cafef00d12345678", i, s_wdata_o); end
      checks++; if (s_wmask_o !== 8'hAA) begin errors++; $display("FAIL bp_wmask[%0d] got %h exp aa", i, s_wmask_o); end
      checks++; if (m_req_ready_o !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 00", i, m_req_ready_o); end
      tick();
    end
    s_req_ready_i = 1'b1;
    tick();
    s_req_ready_i = 1'b0;
    checks++; if (m_req_ready_o !== 2'b00) begin errors++; $display("FAIL bp_resp_ready got %b exp 00", m_req_ready_o); end
    s_resp_valid_i = 1'b1; s_rdata_i = 64'h99;
    tick();
    s_resp_valid_i = 1'b0;
    #1;
    checks++; if (m_resp_valid_o !== 2'b01) begin errors++; $display("FAIL bp_resp got %b exp 01", m_resp_valid_o); end
    checks++; if (m_req_ready_o !== 2'b10) begin errors++; $display("FAIL bp_next_grant got %b exp 10", m_req_ready_o); end
    m_req_valid_i = 2'b00; m_wen_i = 2'b00;
  endtask

  task automatic test_lsu_write();
    do_reset();
    m_addr_i = {32'h0000_5000, 32'h0}; m_wen_i = 2'b10;
    m_wdata_i = {64'hDEAD_BEEF, 64'h0}; m_wmask_i = {8'h0F, 8'h00};
    m_req_valid_i = 2'b10;
    #1;
    checks++; if (m_req_ready_o !== 2'b10) begin errors++; $display("FAIL wr_grant got %b exp 10", m_req_ready_o); end
    tick();
    m_req_valid_i = 2'b00; s_req_ready_i = 1'b1; s_resp_valid_i = 1'b1; s_rdata_i = 64'h55;
    #1;
    checks++; if (s_wmask_o !== 8'h0F) begin errors++; $display("FAIL wr_wmask got %h exp 0f", s_wmask_o); end
    checks++; if (s_wen_o !== 1'b1) begin errors++; $display("FAIL wr_wen got %b exp 1", s_wen_o); end
    checks++; if (s_wdata_o !== 64'hDEAD_BEEF) begin errors++; $display("FAIL wr_wdata got %h exp deadbeef", s_wdata_o); end
    checks++; if (s_addr_o !== 32'h0000_5000) begin errors++; $display("FAIL wr_addr got %h exp 5000", s_addr_o); end
    tick();
    s_req_ready_i = 1'b0; s_resp_valid_i = 1'b0;
    #1;
    checks++; if (m_resp_valid_o !== 2'b10) begin errors++; $display("FAIL wr_resp got %b exp 10", m_resp_valid_o); end
    checks++; if (dut_rr.state_q !== ST_IDLE) begin errors++; $display("FAIL wr_state got %0d exp 0", dut_rr.state_q); end
    checks++; if (s_req_valid_o !== 1'b0) begin errors++; $display("FAIL wr_s_valid got %b exp 0", s_req_valid_o); end
    tick();
    checks++; if (m_resp_valid_o !== 2'b00) begin errors++; $display("FAIL wr_single_pulse got %b exp 00", m_resp_valid_o); end
    m_wen_i = 2'b00;
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    m_addr_i = {32'h0000_6000, 32'h0}; m_req_valid_i = 2'b10; s_req_ready_i = 1'b1;
    tick();
    m_req_valid_i = 2'b00;
    tick();
    s_req_ready_i = 1'b0;
    checks++; if (dut_rr.state_q !== ST_RESP) begin errors++; $display("FAIL rr_in_resp got %0d exp 2", dut_rr.state_q); end
    checks++; if (owner_o !== 1'b1) begin errors++; $display("FAIL rr_pre_owner got %b exp 1", owner_o); end
    rst_i = 1'b1; s_resp_valid_i = 1'b1; s_rdata_i = 64'h77;
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (m_resp_valid_o !== 2'b00) begin errors++; $display("FAIL rir_resp got %b exp 00", m_resp_valid_o); end
    checks++; if (s_req_valid_o !== 1'b0) begin errors++; $display("FAIL rir_s_valid got %b exp 0", s_req_valid_o); end
    checks++; if (dut_rr.state_q !== ST_IDLE) begin errors++; $display("FAIL rir_state got %0d exp 0", dut_rr.state_q); end
    checks++; if (owner_o !== 1'b0) begin errors++; $display("FAIL rir_owner got %b exp 0", owner_o); end
    checks++; if (m_rdata_o !== 64'h0) begin errors++; $display("FAIL rir_rdata got %h exp 0", m_rdata_o); end
    checks++; if (s_addr_o !== 32'h0) begin errors++; $display("FAIL rir_addr got %h exp 0", s_addr_o); end
    tick();
    checks++; if (m_resp_valid_o !== 2'b00) begin errors++; $display("FAIL stray_resp got %b exp 00", m_resp_valid_o); end
    checks++; if (m_rdata_o !== 64'h0) begin errors++; $display("FAIL stray_rdata got %h exp 0", m_rdata_o); end
    s_resp_valid_i = 1'b0;
    tick();
    checks++; if (m_resp_valid_o !== 2'b00) begin errors++; $display("FAIL stray_resp2 got %b exp 00", m_resp_valid_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_rr_contention();
    test_fixed_prio();
    test_backpressure();
    test_lsu_write();
    test_reset_in_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
